rf_ram_port: RTL and testbench

Parametrised RAM-backed register-file slice with a software access port and a hardware access port. It maps a window of the 64-bit software register space onto a single-port RAM of DEPTH words of DATA_W bits. It arbitrates each RAM cycle between hardware (default priority) and software (starvation-guarded), and reports every software access through `access_complete`. It sits inside a generated register file, next to the plain-register decode logic, and succeeds the fixed 32×16 RAM slice.

---
 rtl/rf_ram_pkg.sv | 22 ++
 rtl/rf_ram_sp.sv | 30 +++
 rtl/rf_ram_port.sv | 207 ++++++++++++++++++++
 tb/tb_rf_ram_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ram_pkg.sv
// Shared types for the RAM-backed register-file slice: software FSM states,
// access op and the stall-counter width helper.
package rf_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_RDATA,
        ST_DONE
    } sw_state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } sw_op_e;

    // Wide enough to hold the value STARVE_LIMIT itself.
    function automatic int stall_cnt_w(input int starve_limit);
        return $clog2(starve_limit + 1);
    endfunction

endpackage

// File: rtl/rf_ram_sp.sv
// Single-port synchronous RAM: one access per cycle, registered read data.
module rf_ram_sp #(
    parameter int WIDTH = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(2**AW)-1];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset so the storage
    // maps onto RAM macros; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rf_ram_port.sv
// RAM window of the software register space with a hardware side port.
// Optional feature macro: RF_RAM_PARITY_EN (even parity bit per RAM word).
module rf_ram_port
    import rf_ram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 5,
    parameter int SW_AW        = 6,
    parameter int BASE         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [SW_AW-1:0]  address,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [63:0]       write_data,
    output logic [63:0]       read_data,
    output logic              invalid_address,
    output logic              access_complete,
    input  logic [ADDR_W-1:0] hw_addr,
    input  logic              hw_ren,
    input  logic              hw_wen,
    input  logic [DATA_W-1:0] hw_wdata,
    output logic [DATA_W-1:0] hw_rdata,
    output logic              hw_ready
`ifdef RF_RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SCW   = stall_cnt_w(STARVE_LIMIT);
    localparam logic [63:0] WIN_LO = 64'(BASE);
    localparam logic [63:0] WIN_HI = 64'(BASE) + 64'(DEPTH);
`ifdef RF_RAM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    sw_state_e         state_q, state_d;
    sw_op_e            op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              inv_q, inv_d;
    logic [SCW-1:0]    stall_q, stall_d;
    logic              ack_q, ack_d;
    logic              inv_out_q, inv_out_d;
    logic [63:0]       read_data_q, read_data_d;
    logic              hw_pend_q, hw_pend_d;
    logic [DATA_W-1:0] hw_hold_q, hw_hold_d;

    logic [63:0]       addr_ext;
    logic              in_window;
    logic              hw_req, forced, sw_grant, hw_accept;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata_raw;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic              unused_write_data;

    assign unused_write_data = ^write_data;

    assign addr_ext  = 64'(address);
    assign in_window = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

    // Hardware owns the RAM unless idle or software has waited STARVE_LIMIT cycles.
    assign hw_req    = hw_ren | hw_wen;
    assign forced    = (state_q == ST_PEND) && (stall_q == SCW'(STARVE_LIMIT));
    assign sw_grant  = (state_q == ST_PEND) && (!hw_req || forced);
    assign hw_ready  = !forced;
    assign hw_accept = hw_req && !forced;

    assign ram_we        = sw_grant ? (op_q == OP_WR) : (hw_accept && hw_wen);
    assign ram_re        = sw_grant ? (op_q == OP_RD) : (hw_accept && hw_ren && !hw_wen);
    assign ram_addr      = sw_grant ? addr_q : hw_addr;
    assign ram_wdata_raw = sw_grant ? wdata_q : hw_wdata;
`ifdef RF_RAM_PARITY_EN
    assign ram_wdata = {^ram_wdata_raw, ram_wdata_raw};
`else
    assign ram_wdata = ram_wdata_raw;
`endif

    rf_ram_sp #(
        .WIDTH(RAM_W),
        .AW   (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        inv_d       = inv_q;
        stall_d     = stall_q;
        ack_d       = 1'b0;
        inv_out_d   = 1'b0;
        read_data_d = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (read_en || write_en) begin
                    op_d    = write_en ? OP_WR : OP_RD;
                    addr_d  = address[ADDR_W-1:0];
                    wdata_d = write_data[DATA_W-1:0];
                    inv_d   = !in_window;
                    state_d = in_window ? ST_PEND : ST_DONE;
                end
            end
            ST_PEND: begin
                if (sw_grant) begin
                    stall_d = '0;
                    if (op_q == OP_WR) begin
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else if (hw_req) begin
                    stall_d = stall_q + SCW'(1);
                end
            end
            ST_RDATA: begin
                read_data_d = 64'(ram_rdata[DATA_W-1:0]);
                ack_d       = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_DONE: begin
                // A valid write already acknowledged on commit; only rejects pulse here.
                if (inv_q) begin
                    ack_d       = 1'b1;
                    inv_out_d   = 1'b1;
                    read_data_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hw_pend_d = hw_accept && hw_ren && !hw_wen;
    assign hw_hold_d = hw_pend_q ? ram_rdata[DATA_W-1:0] : hw_hold_q;
    assign hw_rdata  = hw_pend_q ? ram_rdata[DATA_W-1:0] : hw_hold_q;

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            inv_q       <= 1'b0;
            stall_q     <= '0;
            ack_q       <= 1'b0;
            inv_out_q   <= 1'b0;
            read_data_q <= '0;
            hw_pend_q   <= 1'b0;
            hw_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            inv_q       <= inv_d;
            stall_q     <= stall_d;
            ack_q       <= ack_d;
            inv_out_q   <= inv_out_d;
            read_data_q <= read_data_d;
            hw_pend_q   <= hw_pend_d;
            hw_hold_q   <= hw_hold_d;
        end
    end

    assign read_data       = read_data_q;
    assign access_complete = ack_q;
    assign invalid_address = inv_out_q;

`ifdef RF_RAM_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic rd_check;

    assign rd_check     = (state_q == ST_RDATA) || hw_pend_q;
    assign parity_err_d = parity_err_q | (rd_check && (^ram_rdata));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_rf_ram_port.sv
// Self-checking bench for rf_ram_port: directed tables, contention and reset
// sequences, and random traffic against an array model of the RAM window.
`timescale 1ns/1ps
module tb_rf_ram_port;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 5;
    localparam int SW_AW        = 6;
    localparam int BASE         = 32;
    localparam int STARVE_LIMIT = 8;
    localparam int DEPTH        = 32;

    logic              clk;
    logic              res_n;
    logic [SW_AW-1:0]  address;
    logic              read_en;
    logic              write_en;
    logic [63:0]       write_data;
    logic [63:0]       read_data;
    logic              invalid_address;
    logic              access_complete;
    logic [ADDR_W-1:0] hw_addr;
    logic              hw_ren;
    logic              hw_wen;
    logic [DATA_W-1:0] hw_wdata;
    logic [DATA_W-1:0] hw_rdata;
    logic              hw_ready;
`ifdef RF_RAM_PARITY_EN
    logic              parity_err;
`endif

    rf_ram_port #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SW_AW       (SW_AW),
        .BASE        (BASE),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .res_n          (res_n),
        .address        (address),
        .read_en        (read_en),
        .write_en       (write_en),
        .write_data     (write_data),
        .read_data      (read_data),
        .invalid_address(invalid_address),
        .access_complete(access_complete),
        .hw_addr        (hw_addr),
        .hw_ren         (hw_ren),
        .hw_wen         (hw_wen),
        .hw_wdata       (hw_wdata),
        .hw_rdata       (hw_rdata),
        .hw_ready       (hw_ready)
`ifdef RF_RAM_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [63:0] data;
        int          exp_lat;
        logic        exp_inv;
        logic        chk_rd;
        logic [63:0] exp_rd;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] ref_mem [0:DEPTH-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic in_win(input int a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    // Issues one software access; lat counts cycles from the request cycle to the ack cycle.
    task automatic sw_access(input logic wr, input logic [5:0] addr, input logic [63:0] data,
                             output int lat, output logic inv, output logic [63:0] rd);
        write_en   = wr;
        read_en    = !wr;
        address    = addr;
        write_data = data;
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        lat      = 1;
        while (!access_complete && lat < 40) begin
            tick();
            lat++;
        end
        inv = invalid_address;
        rd  = read_data;
        tick();
        check("ack_single_pulse", 64'(access_complete), 64'd0);
    endtask

    // Software access checked against the model; updates the model on in-window writes.
    task automatic sw_model(input string name, input logic wr, input int a, input logic [63:0] data);
        int          lat;
        logic        inv;
        logic [63:0] rd;
        sw_access(wr, 6'(a), data, lat, inv, rd);
        if (!in_win(a)) begin
            check({name, "_lat"}, 64'(lat), 64'd2);
            check({name, "_inv"}, 64'(inv), 64'd1);
            check({name, "_rd"}, rd, 64'd0);
        end else if (wr) begin
            ref_mem[a - BASE] = data[15:0];
            check({name, "_lat"}, 64'(lat), 64'd2);
            check({name, "_inv"}, 64'(inv), 64'd0);
        end else begin
            check({name, "_lat"}, 64'(lat), 64'd3);
            check({name, "_inv"}, 64'(inv), 64'd0);
            check({name, "_rd"}, rd, 64'(ref_mem[a - BASE]));
        end
    endtask

    task automatic hw_write(input int a, input logic [15:0] d);
        hw_addr  = 5'(a);
        hw_wdata = d;
        hw_wen   = 1'b1;
        tick();
        hw_wen = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic hw_read(input string name, input int a, input logic [15:0] exp);
        hw_addr = 5'(a);
        hw_ren  = 1'b1;
        tick();
        hw_ren = 1'b0;
        check(name, 64'(hw_rdata), 64'(exp));
        tick();
        check({name, "_hold"}, 64'(hw_rdata), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        int          lat, cyc, low_cnt, first_low;
        logic        inv;
        logic [63:0] rd;

        vecs[0] = '{1'b1, 6'd33, 64'h1234_5678_9ABC_DEF0, 2, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 6'd33, 64'h0,                   3, 1'b0, 1'b1, 64'hDEF0};
        vecs[2] = '{1'b0, 6'd5,  64'h0,                   2, 1'b1, 1'b1, 64'h0};
        vecs[3] = '{1'b1, 6'd5,  64'hFFFF,                2, 1'b1, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 6'd32, 64'hAAAA_5555,           2, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 6'd63, 64'h1234_0000_C3C3,      2, 1'b0, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 6'd31, 64'h0,                   2, 1'b1, 1'b1, 64'h0};
        vecs[7] = '{1'b0, 6'd32, 64'h0,                   3, 1'b0, 1'b1, 64'h5555};
        vecs[8] = '{1'b0, 6'd63, 64'h0,                   3, 1'b0, 1'b1, 64'hC3C3};
        vecs[9] = '{1'b0, 6'd0,  64'h0,                   2, 1'b1, 1'b1, 64'h0};

        res_n = 1'b0; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
        hw_addr = '0; hw_ren = 1'b0; hw_wen = 1'b0; hw_wdata = '0;
        tick();
        tick();
        check("rst_read_data", read_data, 64'd0);
        check("rst_ack", 64'(access_complete), 64'd0);
        check("rst_inv", 64'(invalid_address), 64'd0);
        check("rst_hw_rdata", 64'(hw_rdata), 64'd0);
        check("rst_hw_ready", 64'(hw_ready), 64'd1);
`ifdef RF_RAM_PARITY_EN
        check("rst_parity_err", 64'(parity_err), 64'd0);
`endif
        res_n = 1'b1;
        tick();

        // Software fills the window, hardware reads it back.
        for (int a = BASE; a < BASE + DEPTH; a++) sw_model("t1_sw_wr", 1'b1, a, 64'(a));
        for (int i = 0; i < DEPTH; i++) hw_read("t1_hw_rd", i, 16'(i + 32));

        // Hardware fills the RAM, software reads it back.
        for (int i = 0; i < DEPTH; i++) hw_write(i, 16'(i));
        for (int a = BASE; a < BASE + DEPTH; a++) sw_model("t2_sw_rd", 1'b0, a, 64'h0);

        // Directed table: truncation, window boundaries, invalid accesses.
        for (int v = 0; v < 10; v++) begin
            sw_access(vecs[v].wr, vecs[v].addr, vecs[v].data, lat, inv, rd);
            check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("vec%0d_inv", v), 64'(inv), 64'(vecs[v].exp_inv));
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
            if (vecs[v].wr && in_win(int'(vecs[v].addr)))
                ref_mem[int'(vecs[v].addr) - BASE] = vecs[v].data[15:0];
        end
        hw_read("t5_trunc", 1, 16'hDEF0);
        hw_read("t3_ram_unchanged", 5, ref_mem[5]);

        // Starvation guard: hardware writes address 0 every cycle.
        hw_addr = 5'd0; hw_wdata = 16'h1111; hw_wen = 1'b1;
        write_en = 1'b1; address = 6'd40; write_data = 64'hBEEF;
        tick();
        write_en = 1'b0;
        cyc = 1; low_cnt = 0; first_low = 0;
        while (!access_complete && cyc < 40) begin
            if (!hw_ready) begin
                low_cnt++;
                if (first_low == 0) first_low = cyc;
            end
            tick();
            cyc++;
        end
        hw_wen = 1'b0;
        check("t4_first_ready_low", 64'(first_low), 64'(STARVE_LIMIT + 1));
        check("t4_ready_low_cycles", 64'(low_cnt), 64'd1);
        check("t4_ack_cycle", 64'(cyc), 64'(STARVE_LIMIT + 2));
        tick();
        ref_mem[0] = 16'h1111;
        ref_mem[8] = 16'hBEEF;
        hw_read("t4_hw_rd_8", 8, 16'hBEEF);
        hw_read("t4_hw_rd_0", 0, 16'h1111);

        // Starvation guard on a software read while hardware keeps reading.
        hw_addr = 5'd3; hw_ren = 1'b1;
        read_en = 1'b1; address = 6'd34;
        tick();
        read_en = 1'b0;
        cyc = 1;
        while (!access_complete && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t4r_ack_cycle", 64'(cyc), 64'(STARVE_LIMIT + 3));
        check("t4r_read_data", read_data, 64'(ref_mem[2]));
        check("t4r_hw_rdata", 64'(hw_rdata), 64'(ref_mem[3]));
        hw_ren = 1'b0;
        tick();

        // Random mixed traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int          k, a;
            logic [63:0] d;
            k = int'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            case (k)
                0: hw_write(int'($urandom_range(0, DEPTH - 1)), d[15:0]);
                1: begin
                    a = int'($urandom_range(0, DEPTH - 1));
                    hw_read("rnd_hw_rd", a, ref_mem[a]);
                end
                2: sw_model("rnd_sw_wr", 1'b1, int'($urandom_range(0, 63)), d);
                default: sw_model("rnd_sw_rd", 1'b0, int'($urandom_range(0, 63)), d);
            endcase
        end

`ifdef RF_RAM_PARITY_EN
        dut.u_ram.mem[4] = dut.u_ram.mem[4] ^ 17'h1;
        hw_read("par_data_returned", 4, ref_mem[4] ^ 16'h1);
        check("par_err_set", 64'(parity_err), 64'd1);
        tick();
        tick();
        check("par_err_sticky", 64'(parity_err), 64'd1);
        dut.u_ram.mem[4] = dut.u_ram.mem[4] ^ 17'h1;
`endif

        // Reset while the software read sits in RDATA.
        hw_read("t6_pre_hw_rd", 1, ref_mem[1]);
        read_en = 1'b1; address = 6'd33;
        tick();
        read_en = 1'b0;
        tick();
        res_n = 1'b0;
        #1;
        check("t6_read_data", read_data, 64'd0);
        check("t6_ack", 64'(access_complete), 64'd0);
        check("t6_inv", 64'(invalid_address), 64'd0);
        check("t6_hw_rdata", 64'(hw_rdata), 64'd0);
        check("t6_hw_ready", 64'(hw_ready), 64'd1);
`ifdef RF_RAM_PARITY_EN
        check("t6_parity_err", 64'(parity_err), 64'd0);
`endif
        tick();
        tick();
        res_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_ack", 64'(access_complete), 64'd0);
            tick();
        end
        sw_model("t6_after_rst", 1'b0, 33, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
